// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the dense-network sequencer and its helpers.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    ERROR = 3'd4
  } seq_state_e;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(3);

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer watchdog: counts RUN cycles starting at 1 and flags when the
// current cycle is the TIMEOUT-th one.
module layer_watchdog import nn_ctrl_pkg::*; #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] cnt_r;

  // Clear preloads 1 so the first enabled cycle already reads as count 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= WD_W'(1);
    end else if (clear) begin
      cnt_r <= WD_W'(1);
    end else if (count_en && (cnt_r != WD_W'(TIMEOUT))) begin
      cnt_r <= cnt_r + WD_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = count_en && (cnt_r == WD_W'(TIMEOUT));

endmodule

// File: rtl/dense_network_sequencer.sv
// Sequences a chain of dense layers: reset pulse, enable until done, then the
// next layer; watchdog per layer and a valid/ready result handshake.
module dense_network_sequencer import nn_ctrl_pkg::*; #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = idx_width(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done_i,
  output logic [NUM_LAYERS-1:0] layer_en_o,
  output logic [NUM_LAYERS-1:0] layer_rst_o,
  output logic [IDX_W-1:0]      cur_layer,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  error,
  output logic [CNT_W-1:0]      pass_cycles
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  seq_state_e state_r;
  logic       run_s;
  logic       expired_s;
  logic       done_cur_s;

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LAYERS-1:0] v;
    v      = {NUM_LAYERS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign run_s      = (state_r == RUN);
  assign done_cur_s = layer_done_i[cur_layer];

  layer_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (!run_s),
    .count_en (run_s),
    .expired  (expired_s)
  );

  // Moore FSM: state, layer index, cycle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      layer_en_o   <= {NUM_LAYERS{1'b0}};
      layer_rst_o  <= {NUM_LAYERS{1'b0}};
      cur_layer    <= {IDX_W{1'b0}};
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      pass_cycles  <= {CNT_W{1'b0}};
    end else begin
      // Pulses and enables are rebuilt every cycle from the destination state.
      layer_en_o  <= {NUM_LAYERS{1'b0}};
      layer_rst_o <= {NUM_LAYERS{1'b0}};
      if (((state_r == CLEAR) || run_s) && (pass_cycles != CNT_MAX)) begin
        pass_cycles <= pass_cycles + CNT_W'(1);
      end else begin
        pass_cycles <= pass_cycles;
      end

      if (abort && (state_r != IDLE)) begin
        // Abort resets every layer at once and parks in IDLE.
        state_r      <= IDLE;
        layer_rst_o  <= {NUM_LAYERS{1'b1}};
        busy         <= 1'b0;
        result_valid <= 1'b0;
        error        <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r     <= CLEAR;
              cur_layer   <= {IDX_W{1'b0}};
              pass_cycles <= {CNT_W{1'b0}};
              layer_rst_o <= onehot({IDX_W{1'b0}});
              busy        <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
          CLEAR: begin
            state_r    <= RUN;
            layer_en_o <= onehot(cur_layer);
          end
          RUN: begin
            // Done wins over a simultaneous watchdog expiry.
            if (done_cur_s && (cur_layer == LAST_IDX)) begin
              state_r      <= HOLD;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else if (done_cur_s) begin
              state_r     <= CLEAR;
              cur_layer   <= cur_layer + IDX_W'(1);
              layer_rst_o <= onehot(cur_layer + IDX_W'(1));
            end else if (expired_s) begin
              state_r <= ERROR;
              busy    <= 1'b0;
              error   <= 1'b1;
            end else begin
              layer_en_o <= onehot(cur_layer);
            end
          end
          HOLD: begin
            if (result_ready) begin
              state_r      <= IDLE;
              result_valid <= 1'b0;
            end else begin
              state_r <= HOLD;
            end
          end
          ERROR: begin
            if (start) begin
              state_r     <= CLEAR;
              cur_layer   <= {IDX_W{1'b0}};
              pass_cycles <= {CNT_W{1'b0}};
              layer_rst_o <= onehot({IDX_W{1'b0}});
              busy        <= 1'b1;
              error       <= 1'b0;
            end else begin
              state_r <= ERROR;
            end
          end
          default: begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dense_network_sequencer.sv
// Directed, table-driven bench for dense_network_sequencer (3 layers, TIMEOUT 16).
module tb_dense_network_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  layer_done_i = 3'b000;
  logic        result_ready = 1'b0;
  logic [2:0]  layer_en_o;
  logic [2:0]  layer_rst_o;
  logic [1:0]  cur_layer;
  logic        busy;
  logic        result_valid;
  logic        error;
  logic [31:0] pass_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        s, a;
    logic [2:0]  d;
    logic        r;
    logic [2:0]  en, rst;
    logic [1:0]  cur;
    logic        bsy, vld, err;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  dense_network_sequencer #(.NUM_LAYERS(3), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .layer_done_i (layer_done_i),
    .layer_en_o   (layer_en_o),
    .layer_rst_o  (layer_rst_o),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error),
    .pass_cycles  (pass_cycles)
  );

  always #5 clk = ~clk;

  task automatic push(input logic s, a, input logic [2:0] d, input logic r,
                      input logic [2:0] en, rst, input logic [1:0] cur,
                      input logic bsy, vld, err, input logic [31:0] pc);
    vec_t v;
    v.s = s; v.a = a; v.d = d; v.r = r;
    v.en = en; v.rst = rst; v.cur = cur;
    v.bsy = bsy; v.vld = vld; v.err = err; v.pc = pc;
    tbl.push_back(v);
  endtask

  // Drive inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic s, a, input logic [2:0] d, input logic r);
    start = s; abort = a; layer_done_i = d; result_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] en, rst,
                     input logic [1:0] cur, input logic bsy, vld, err,
                     input logic [31:0] pc);
    logic [42:0] act, exp;
    act = {layer_en_o, layer_rst_o, cur_layer, busy, result_valid, error, pass_cycles};
    exp = {en, rst, cur, bsy, vld, err, pc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en=%b rst=%b cur=%0d busy=%b valid=%b err=%b pc=%0d, want en=%b rst=%b cur=%0d busy=%b valid=%b err=%b pc=%0d",
               name, layer_en_o, layer_rst_o, cur_layer, busy, result_valid, error, pass_cycles,
               en, rst, cur, bsy, vld, err, pc);
    end
  endtask

  initial begin
    // Nominal pass: each layer's done arrives on its 5th RUN cycle.
    // Row k holds inputs of cycle k and expected outputs of cycle k+1.
    push(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    push(1'b0, 1'b0, 3'b000, 1'b0, 3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 32'd1);
    for (int k = 2; k <= 5; k++)
      push(1'b0, 1'b0, (k == 3) ? 3'b100 : 3'b000, 1'b0, 3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 32'(k));
    push(1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0, 32'd6);
    push(1'b0, 1'b0, 3'b000, 1'b0, 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 32'd7);
    for (int k = 8; k <= 11; k++)
      push(1'b0, 1'b0, (k == 9) ? 3'b001 : 3'b000, 1'b0, 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 32'(k));
    push(1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 1'b0, 32'd12);
    for (int k = 13; k <= 17; k++)
      push(1'b0, 1'b0, 3'b000, 1'b0, 3'b100, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 32'(k));
    push(1'b0, 1'b0, 3'b100, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 1'b0, 32'd18);
    for (int k = 19; k <= 22; k++)
      push((k == 20), 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 1'b0, 32'd18);
    push(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 32'd18);
    push(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 32'd18);

    // Reset state.
    step(1'b1, 1'b1, 3'b111, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("reset", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("idle", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].rst, tbl[i].cur,
          tbl[i].bsy, tbl[i].vld, tbl[i].err, tbl[i].pc);
    end

    // Timeout on layer 1, then restart from ERROR.
    step(1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b001, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("to_run1", 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 32'd3);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("to_run16", 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 32'd18);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("to_error", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 1'b1, 32'd19);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("error_hold", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 1'b1, 32'd19);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    chk("err_restart", 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Done on exactly the 16th RUN cycle of layer 0 advances without error.
    step(1'b0, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("edge_run16", 3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 32'd16);
    step(1'b0, 1'b0, 3'b001, 1'b0);
    chk("edge_done", 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0, 32'd17);

    // Abort during RUN of layer 2.
    step(1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("ab_run2", 3'b100, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 32'd20);
    step(1'b0, 1'b1, 3'b000, 1'b0);
    if (1'b1) begin
      checks++;
      if (layer_rst_o !== 3'b111 || busy !== 1'b0 || layer_en_o !== 3'b000) begin
        errors++;
        $display("FAIL abort_pulse: got rst=%b busy=%b en=%b, want rst=111 busy=0 en=000",
                 layer_rst_o, busy, layer_en_o);
      end
    end
    step(1'b0, 1'b0, 3'b000, 1'b0);
    checks++;
    if (layer_rst_o !== 3'b000 || busy !== 1'b0 || layer_en_o !== 3'b000) begin
      errors++;
      $display("FAIL abort_after: got rst=%b busy=%b en=%b, want rst=000 busy=0 en=000",
               layer_rst_o, busy, layer_en_o);
    end

    // Reset together with abort during RUN of layer 1.
    step(1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b001, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("rs_run1", 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 32'd3);
    reset = 1'b0;
    step(1'b0, 1'b1, 3'b000, 1'b0);
    chk("rs_mid", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("rs_after", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
